// File: rtl/insn_mem_pkg.sv
// insn_mem_pkg: shared types and constants for the instruction-memory responder.
package insn_mem_pkg;
  localparam int RSP_DW = 32;
  localparam int RSP_DEPTH = 2;
  localparam int ERR_CNT_W = 16;
  typedef struct packed {
    logic [RSP_DW-1:0] data;
    logic err;
  } rsp_t;
endpackage

// File: rtl/insn_mem_responder_rsp_fifo.sv
// rsp_fifo: 2-entry response FIFO; the head reads as zero when empty.
module rsp_fifo
  import insn_mem_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  rsp_t din,
  output logic full,
  output logic empty,
  output rsp_t head
);
  rsp_t mem [RSP_DEPTH];
  logic [1:0] cnt;
  logic wp, rp;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      wp <= 1'b0;
      rp <= 1'b0;
    end else begin
      if (push) wp <= ~wp;
      if (pop) rp <= ~rp;
      cnt <= cnt + 2'(push) - 2'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
  assign full = cnt == 2'(RSP_DEPTH);
  assign empty = cnt == '0;
  assign head = empty ? '0 : mem[rp];
endmodule

// File: rtl/insn_mem_responder.sv
// insn_mem_responder: instruction array behind a valid/ready fetch request/response path.
module insn_mem_responder
  import insn_mem_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32,
  parameter logic [AWIDTH-1:0] BASEADDR = 32'h01000000,
  parameter int MEM_WORDS = 1024,
  localparam int LW = $clog2(MEM_WORDS)
) (
  input  logic clk,
  input  logic rst,
  input  logic req_valid,
  output logic req_ready,
  input  logic [AWIDTH-1:0] req_addr,
  output logic rsp_valid,
  input  logic rsp_ready,
  output logic [DWIDTH-1:0] rsp_data,
  output logic rsp_err,
  input  logic load_we,
  input  logic [LW-1:0] load_idx,
  input  logic [DWIDTH-1:0] load_data,
  output logic [ERR_CNT_W-1:0] err_count
);
  localparam logic [AWIDTH:0] LO = {1'b0, BASEADDR};
  localparam logic [AWIDTH:0] HI = LO + (AWIDTH+1)'(4 * MEM_WORDS);
  logic [DWIDTH-1:0] mem [MEM_WORDS];
  logic full, empty, accept, pop, err;
  logic [AWIDTH:0] addr_x;
  logic [LW-1:0] idx;
  rsp_t din, head;
  assign addr_x = {1'b0, req_addr};
  assign err = (req_addr[1:0] != 2'b00) || (addr_x < LO) || (addr_x >= HI);
  assign idx = LW'((req_addr - BASEADDR) >> 2);
  assign req_ready = !rst && !full;
  assign accept = req_valid && req_ready;
  assign pop = rsp_valid && rsp_ready;
  assign din = '{data: err ? '0 : mem[idx], err: err};
  // The array read happens at the accepting edge, so a same-edge load sees the old word.
  always_ff @(posedge clk)
    if (load_we) mem[load_idx] <= load_data;
  rsp_fifo u_fifo (
    .clk(clk), .rst(rst), .push(accept), .pop(pop), .din(din),
    .full(full), .empty(empty), .head(head)
  );
  assign rsp_valid = !empty;
  assign rsp_data = head.data;
  assign rsp_err = head.err;
  always_ff @(posedge clk or posedge rst)
    if (rst) err_count <= '0;
    else if (pop && head.err && err_count != '1) err_count <= err_count + 1'b1;
endmodule

// File: tb/tb_insn_mem_responder.sv
// tb_insn_mem_responder: directed checks of fetch responses, backpressure, load port and error counter.
module tb_insn_mem_responder;
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_ready, rsp_valid, rsp_ready = 0, rsp_err, load_we = 0;
  logic [31:0] req_addr = 0, rsp_data, load_data = 0;
  logic [9:0] load_idx = 0;
  logic [15:0] err_count;
  int total = 0, bad = 0;
  logic [31:0] prog [4] = '{32'h00000013, 32'h00100093, 32'h00200113, 32'h00300193};
  always #5 clk = ~clk;
  insn_mem_responder dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .load_we(load_we), .load_idx(load_idx), .load_data(load_data), .err_count(err_count)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    #2;
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL rst_req_ready got=%b exp=0", req_ready); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid); end
    total++; if (rsp_data !== 32'h0 || rsp_err !== 1'b0) begin bad++; $display("FAIL rst_rsp got=%h/%b exp=0/0", rsp_data, rsp_err); end
    total++; if (err_count !== 16'h0) begin bad++; $display("FAIL rst_err_count got=%h exp=0", err_count); end
    tick;
    rst = 0;
    tick;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL post_rst_req_ready got=%b exp=1", req_ready); end
  endtask
  task automatic test_back_to_back;
    for (int i = 0; i < 4; i++) begin
      load_we = 1; load_idx = 10'(i); load_data = prog[i];
      tick;
    end
    load_idx = 10'd5; load_data = 32'h0;
    tick;
    load_we = 0;
    rsp_ready = 1;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1; req_addr = 32'h01000000 + 32'(4 * i);
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready%0d got=%b exp=1", i, req_ready); end
      tick;
      total++;
      if (rsp_valid !== 1'b1 || rsp_data !== prog[i] || rsp_err !== 1'b0) begin
        bad++; $display("FAIL b2b_rsp%0d got=%b/%h/%b exp=1/%h/0", i, rsp_valid, rsp_data, rsp_err, prog[i]);
      end
    end
    req_valid = 0;
    tick;
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b exp=0", rsp_valid); end
  endtask
  task automatic test_errors;
    logic [31:0] addrs [3] = '{32'h01000002, 32'h00FFFFFC, 32'h01001000};
    for (int i = 0; i < 3; i++) begin
      req_valid = 1; req_addr = addrs[i];
      tick;
      req_valid = 0;
      total++;
      if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== 32'h0) begin
        bad++; $display("FAIL err_rsp%0d got=%b/%b/%h exp=1/1/0", i, rsp_valid, rsp_err, rsp_data);
      end
      tick;
      total++; if (err_count !== 16'(i + 1)) begin bad++; $display("FAIL err_count%0d got=%0d exp=%0d", i, err_count, i + 1); end
    end
  endtask
  task automatic test_backpressure;
    logic [31:0] got [$];
    int sent = 0;
    rsp_ready = 0;
    for (int c = 0; c < 4; c++) begin
      req_valid = 1; req_addr = 32'h01000000 + 32'(4 * sent);
      if (req_ready) sent++;
      tick;
    end
    total++; if (sent !== 2) begin bad++; $display("FAIL bp_accepted got=%0d exp=2", sent); end
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL bp_ready got=%b exp=0", req_ready); end
    total++; if (rsp_data !== prog[0]) begin bad++; $display("FAIL bp_stable got=%h exp=%h", rsp_data, prog[0]); end
    rsp_ready = 1;
    for (int c = 0; c < 20 && got.size() < 5; c++) begin
      req_valid = sent < 4; req_addr = 32'h01000000 + 32'(4 * sent);
      if (rsp_valid) got.push_back(rsp_data);
      if (req_valid && req_ready) sent++;
      tick;
    end
    req_valid = 0;
    total++; if (got.size() !== 4) begin bad++; $display("FAIL bp_count got=%0d exp=4", got.size()); end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      total++; if (got[i] !== prog[i]) begin bad++; $display("FAIL bp_order%0d got=%h exp=%h", i, got[i], prog[i]); end
    end
  endtask
  task automatic test_load_collision;
    load_we = 1; load_idx = 10'd5; load_data = 32'hDEADBEEF;
    req_valid = 1; req_addr = 32'h01000014;
    tick;
    load_we = 0;
    total++; if (rsp_data !== 32'h0) begin bad++; $display("FAIL rbw_old got=%h exp=00000000", rsp_data); end
    tick;
    req_valid = 0;
    total++; if (rsp_data !== 32'hDEADBEEF) begin bad++; $display("FAIL rbw_new got=%h exp=deadbeef", rsp_data); end
    tick;
  endtask
  task automatic test_async_reset;
    rsp_ready = 0; req_valid = 1; req_addr = 32'h01000000;
    tick;
    req_addr = 32'h01000004;
    tick;
    req_valid = 0;
    total++; if (rsp_valid !== 1'b1 || req_ready !== 1'b0) begin bad++; $display("FAIL ar_pre got=%b/%b exp=1/0", rsp_valid, req_ready); end
    #2 rst = 1;
    #1;
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL ar_valid got=%b exp=0", rsp_valid); end
    total++; if (err_count !== 16'h0) begin bad++; $display("FAIL ar_err_count got=%h exp=0", err_count); end
    tick;
    #2 rst = 0;
    tick;
    rsp_ready = 1; req_valid = 1; req_addr = 32'h01000000;
    tick;
    req_valid = 0;
    total++; if (rsp_valid !== 1'b1 || rsp_data !== prog[0]) begin bad++; $display("FAIL ar_keep got=%b/%h exp=1/%h", rsp_valid, rsp_data, prog[0]); end
    tick;
  endtask
  task automatic test_saturation;
    rst = 1;
    #1 rst = 0;
    rsp_ready = 1; req_valid = 1; req_addr = 32'h01000002;
    for (int i = 0; i < 65535; i++) tick;
    total++; if (err_count !== 16'hFFFE) begin bad++; $display("FAIL sat_pre got=%h exp=fffe", err_count); end
    for (int i = 0; i < 5; i++) tick;
    req_valid = 0;
    tick;
    total++; if (err_count !== 16'hFFFF) begin bad++; $display("FAIL sat_hold got=%h exp=ffff", err_count); end
  endtask
  initial begin
    test_reset;
    test_back_to_back;
    test_errors;
    test_backpressure;
    test_load_collision;
    test_async_reset;
    test_saturation;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/insn_mem_responder.md
Name: insn_mem_responder

Overview:
- Instruction-memory responder: the target end of the fetch-stage instruction request path.
- Accepts word-aligned byte addresses from fetch over a valid/ready request channel. Returns the 32-bit instruction, or an error, over a valid/ready response channel.
- Holds a word-addressed instruction array, filled through a side load port by the bench or boot loader. Sits between the fetch stage and the program image.

Parameters:
- DWIDTH, 32, instruction/data word width.
- AWIDTH, 32, byte address width.
- BASEADDR, 32'h01000000, byte address of word 0.
- MEM_WORDS, 1024, array depth in words; power of two.
- LW, $clog2(MEM_WORDS), load-port word-index width (derived, not overridable).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  fetch request present
- req_ready  out  1  responder can accept a request
- req_addr  in  AWIDTH  byte address of requested instruction
- rsp_valid  out  1  response present
- rsp_ready  in  1  fetch consumes response
- rsp_data  out  DWIDTH  instruction word; 0 when rsp_err=1
- rsp_err  out  1  misaligned or out-of-range request
- load_we  in  1  write one word into the array
- load_idx  in  LW  word index for load
- load_data  in  DWIDTH  word to store
- err_count  out  16  saturating count of error responses issued

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: req_ready=1 after reset deasserts (0 while rst high), rsp_valid=0, rsp_data=0, rsp_err=0, err_count=0. The array is not cleared by reset.
- Request acceptance:
  - A request is accepted on the rising edge where req_valid && req_ready.
  - req_ready = (occupancy < 2). It is a pure function of state, with no combinational path from rsp_ready.
- Address check on the accepted address:
  - err = (req_addr[1:0] != 0) || (req_addr < BASEADDR) || (req_addr >= BASEADDR + 4*MEM_WORDS).
  - Compare at AWIDTH+1 bits so that BASEADDR+4*MEM_WORDS cannot wrap.
  - Word index = (req_addr - BASEADDR) >> 2, truncated to LW bits.
- Read timing:
  - The array is read at the accepting edge and {data, err} is pushed into a 2-entry response FIFO.
  - Latency: a request accepted at edge N with the FIFO empty gives rsp_valid=1 in the cycle after edge N (1-cycle latency).
- Response FIFO:
  - The FIFO head drives rsp_data/rsp_err; rsp_valid = !empty.
  - The head pops on the edge where rsp_valid && rsp_ready.
  - Push and pop on the same edge leave occupancy unchanged.
  - Order is strictly preserved.
- Backpressure: while rsp_ready=0, at most 2 responses are buffered. req_ready drops at occupancy 2 and returns the cycle after a pop. Responses are never lost or duplicated.
- Response stability: rsp_data/rsp_err hold stable while rsp_valid && !rsp_ready.
- Load port:
  - Writes on the rising edge when load_we=1.
  - A load and a read of the same word on the same edge return the old word (read-before-write).
  - Loads are legal at any time, including during traffic.
- err_count: increments on each popped response with err=1 and saturates at 16'hFFFF.
- Reset mid-operation: the FIFO is flushed immediately (asynchronously), rsp_valid=0, and in-flight requests are discarded. Array contents are kept.

Decomposition:
- Package insn_mem_pkg:
  - rsp_t struct {logic [DWIDTH-1:0] data; logic err;}
  - RSP_DEPTH=2
  - ERR_CNT_W=16
- Sub-module rsp_fifo: a 2-entry synchronous FIFO of rsp_t with async reset, push/pop/full/empty and head output.
- Top level contains the array, the address check, the load port and err_count.

Test Plan:
- Load words 0..3 with 32'h00000013, 32'h00100093, 32'h00200113, 32'h00300193, with rsp_ready=1 held. Request addrs 0x01000000, 0x01000004, 0x01000008, 0x0100000C back-to-back -> rsp_valid from the cycle after the first accept, data in that order, err=0, req_ready stays 1.
- Request 0x01000002 -> err=1, data=0, err_count=1. Request 0x00FFFFFC -> err=1. Request 0x01001000 (MEM_WORDS=1024) -> err=1, err_count=3.
- Hold rsp_ready=0 and drive 4 back-to-back requests -> exactly 2 accepted, req_ready=0 and data stable. Then raise rsp_ready -> the 4 responses come out in order, none lost or duplicated.
- Same edge: load_we to idx 5 with 32'hDEADBEEF and a request for 0x01000014 (old word 32'h0) -> response 32'h0. A repeat request -> 32'hDEADBEEF.
- Assert rst asynchronously (mid-clock) with 2 buffered responses -> rsp_valid falls before the next edge, err_count=0. After release, a request for 0x01000000 still returns 32'h00000013.
- Force 65536 error responses -> err_count saturates at 16'hFFFF and does not wrap.
